// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_pkg
//  Description : Shared encodings for the IF/MEM memory bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Bus FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t ADDR = 2'd1;
    localparam arb_state_t DATA = 2'd2;

    // Access size codes carried on bus_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Which requester owns the outstanding transaction
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_result_buf.sv
`default_nettype none
// ============================================================================
//  Module      : arb_result_buf
//  Description : Per-requester result holding register. Holds a completed
//                bus result until the owning stage releases it or a flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_result_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [DATA_W-1:0] i_setData,
    input  logic              i_release,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_valid;
    logic [DATA_W-1:0] r_rdata;

    // Valid flag: flush dominates; a fresh result beats a same-cycle release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end else if (i_release) begin
            r_valid <= 1'b0;
        end
    end

    // Result data only changes when a kept result arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_set) begin
            r_rdata <= i_setData;
        end
    end

    assign o_valid = r_valid;
    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one SRAM-like bus between IF fetch and MEM data
//                access. Data has priority, one transaction outstanding,
//                results buffered until the owning stage advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_release,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              data_release,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t r_state;
    arb_state_t w_stateNext;
    logic       r_owner;
    logic       r_discard;
    logic       w_grantData;
    logic       w_grantInst;
    logic       w_complete;
    logic       w_commit;
    logic       w_instValid;
    logic       w_dataValid;

    // Next-state, grant and completion decode
    always_comb begin
        w_stateNext = r_state;
        w_grantData = 1'b0;
        w_grantInst = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!flush) begin
                    if (data_req && !w_dataValid) begin
                        w_grantData = 1'b1;
                        w_stateNext = ADDR;
                    end else if (inst_req && !w_instValid) begin
                        w_grantInst = 1'b1;
                        w_stateNext = ADDR;
                    end
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        w_complete  = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    w_complete  = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A completing result is kept only if not discarded and not flushed now
    assign w_commit = w_complete & ~r_discard & ~flush;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Registered bus request and the request fields latched at grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= SIZE_B;
            bus_addr  <= '0;
            bus_wdata <= '0;
            r_owner   <= OWNER_INST;
        end else begin
            bus_req <= (w_stateNext == ADDR);
            if (w_grantData) begin
                r_owner   <= OWNER_DATA;
                bus_wr    <= data_wr;
                bus_size  <= data_size;
                bus_addr  <= data_addr;
                bus_wdata <= data_wdata;
            end else if (w_grantInst) begin
                r_owner   <= OWNER_INST;
                bus_wr    <= 1'b0;
                bus_size  <= SIZE_W;
                bus_addr  <= inst_addr;
                bus_wdata <= '0;
            end
        end
    end

    // Discard marks an in-flight transaction whose result a flush killed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_discard <= 1'b0;
        end else if (w_complete) begin
            r_discard <= 1'b0;
        end else if (flush && (r_state != IDLE)) begin
            r_discard <= 1'b1;
        end
    end

    arb_result_buf #(.DATA_W(DATA_W)) u_instBuf (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_commit && (r_owner == OWNER_INST)),
        .i_setData (bus_rdata),
        .i_release (inst_release),
        .i_flush   (flush),
        .o_valid   (w_instValid),
        .o_rdata   (inst_rdata)
    );

    arb_result_buf #(.DATA_W(DATA_W)) u_dataBuf (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_commit && (r_owner == OWNER_DATA)),
        .i_setData (bus_rdata),
        .i_release (data_release),
        .i_flush   (flush),
        .o_valid   (w_dataValid),
        .o_rdata   (data_rdata)
    );

    assign inst_stall = inst_req & ~w_instValid;
    assign data_stall = data_req & ~w_dataValid;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//                with literal expectations, then randomized traffic against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_release = 1'b0;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_release = 1'b0;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic        flush = 1'b0;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    int nChecks = 0;
    int nErrors = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_release (inst_release),
        .inst_rdata   (inst_rdata),
        .inst_stall   (inst_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_release (data_release),
        .data_rdata   (data_rdata),
        .data_stall   (data_stall),
        .flush        (flush),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction: pending, whether its address was accepted,
    // who it belongs to and whether its result must be thrown away.
    bit          mPending = 0;
    bit          mAddrDone = 0;
    bit          mDrop = 0;
    int          mOwner = 0;           // 0 = inst, 1 = data
    bit          mWr = 0;
    logic [1:0]  mSize = 2'd0;
    logic [31:0] mAddr = '0;
    logic [31:0] mWdata = '0;
    bit          mValid [2] = '{0, 0};
    logic [31:0] mRdata [2] = '{32'h0, 32'h0};
    bit          mDone;
    bit          mNewValid [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPending = 0; mAddrDone = 0; mDrop = 0; mOwner = 0;
            mWr = 0; mSize = 2'd0; mAddr = '0; mWdata = '0;
            mValid = '{0, 0};
            mRdata = '{32'h0, 32'h0};
        end else begin
            mDone = mPending && (mAddrDone ? bus_data_ok : (bus_addr_ok && bus_data_ok));
            mNewValid = mValid;
            if (inst_release) mNewValid[0] = 0;
            if (data_release) mNewValid[1] = 0;
            if (mDone && !mDrop && !flush) begin
                mNewValid[mOwner] = 1;
                mRdata[mOwner] = bus_rdata;
            end
            if (flush) mNewValid = '{0, 0};
            if (mDone) mDrop = 0;
            else if (flush && mPending) mDrop = 1;
            if (mDone) begin
                mPending = 0;
                mAddrDone = 0;
            end else if (mPending) begin
                if (bus_addr_ok) mAddrDone = 1;
            end else if (!flush) begin
                if (data_req && !mValid[1]) begin
                    mPending = 1; mAddrDone = 0; mOwner = 1;
                    mWr = data_wr; mSize = data_size; mAddr = data_addr; mWdata = data_wdata;
                end else if (inst_req && !mValid[0]) begin
                    mPending = 1; mAddrDone = 0; mOwner = 0;
                    mWr = 0; mSize = 2'd2; mAddr = inst_addr; mWdata = '0;
                end
            end
            mValid = mNewValid;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("bus_req", {31'b0, bus_req}, {31'b0, mPending && !mAddrDone});
        if (mPending && !mAddrDone) begin
            check("bus_addr", bus_addr, mAddr);
            check("bus_wr", {31'b0, bus_wr}, {31'b0, mWr});
            check("bus_size", {30'b0, bus_size}, {30'b0, mSize});
            if (mWr) check("bus_wdata", bus_wdata, mWdata);
        end
        check("inst_rdata", inst_rdata, mRdata[0]);
        check("data_rdata", data_rdata, mRdata[1]);
        check("inst_stall", {31'b0, inst_stall}, {31'b0, inst_req && !mValid[0]});
        check("data_stall", {31'b0, data_stall}, {31'b0, data_req && !mValid[1]});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic setOk(input logic a, input logic d, input logic [31:0] rd);
        bus_addr_ok = a;
        bus_data_ok = d;
        bus_rdata   = rd;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        check("rst_stalls", {30'b0, inst_stall, data_stall}, 32'd0);
        cyc();

        // ---------------- single fetch ----------------
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        #1 check("f_c0_stall", {31'b0, inst_stall}, 32'd1);
        check("f_c0_req", {31'b0, bus_req}, 32'd0);
        cyc();
        check("f_c1_req", {31'b0, bus_req}, 32'd1);
        check("f_c1_addr", bus_addr, 32'hBFC00000);
        check("f_c1_size", {30'b0, bus_size}, 32'd2);
        setOk(1'b1, 1'b0, 32'h0);
        #1 check("f_c1_stall", {31'b0, inst_stall}, 32'd1);
        cyc();
        check("f_c2_req", {31'b0, bus_req}, 32'd0);
        setOk(1'b0, 1'b1, 32'h24080001);
        #1 check("f_c2_stall", {31'b0, inst_stall}, 32'd1);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        #1 check("f_c3_stall", {31'b0, inst_stall}, 32'd0);
        check("f_rdata", inst_rdata, 32'h24080001);

        // ---------------- hold without re-issue ----------------
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_req", {31'b0, bus_req}, 32'd0);
            check("hold_stall", {31'b0, inst_stall}, 32'd0);
        end
        inst_release = 1'b1;
        cyc();
        inst_release = 1'b0;
        check("rel_c1_req", {31'b0, bus_req}, 32'd0);
        #1 check("rel_c1_stall", {31'b0, inst_stall}, 32'd1);
        cyc();
        check("rel_c2_req", {31'b0, bus_req}, 32'd1);
        setOk(1'b1, 1'b1, 32'h24080002);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        check("rel_rdata", inst_rdata, 32'h24080002);
        inst_req = 1'b0; inst_release = 1'b1;
        cyc();
        inst_release = 1'b0;

        // ---------------- simultaneous requests ----------------
        inst_req = 1'b1; inst_addr = 32'h00400000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000010;
        cyc();
        check("sim_first_addr", bus_addr, 32'h80000010);
        setOk(1'b1, 1'b1, 32'h11112222);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        check("sim_gap_req", {31'b0, bus_req}, 32'd0);
        check("sim_drdata", data_rdata, 32'h11112222);
        #1 check("sim_stalls", {30'b0, inst_stall, data_stall}, 32'd2);
        cyc();
        check("sim_second_addr", bus_addr, 32'h00400000);
        setOk(1'b1, 1'b1, 32'h33334444);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        check("sim_irdata", inst_rdata, 32'h33334444);
        inst_req = 1'b0; data_req = 1'b0; inst_release = 1'b1; data_release = 1'b1;
        cyc();
        inst_release = 1'b0; data_release = 1'b0;

        // ---------------- store ----------------
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h80000003; data_wdata = 32'h000000AB;
        cyc();
        check("st_req", {31'b0, bus_req}, 32'd1);
        check("st_wr", {31'b0, bus_wr}, 32'd1);
        check("st_size", {30'b0, bus_size}, 32'd0);
        check("st_wdata", bus_wdata, 32'h000000AB);
        setOk(1'b1, 1'b1, 32'h0);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        check("st_req_drop", {31'b0, bus_req}, 32'd0);
        #1 check("st_stall", {31'b0, data_stall}, 32'd0);
        cyc();
        check("st_no_reissue", {31'b0, bus_req}, 32'd0);
        data_req = 1'b0; data_wr = 1'b0; data_release = 1'b1;
        cyc();
        data_release = 1'b0;

        // ---------------- flush mid-transaction ----------------
        inst_req = 1'b1; inst_addr = 32'h00400100;
        cyc();
        setOk(1'b1, 1'b0, 32'h0);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        flush = 1'b1; inst_req = 1'b0;
        cyc();
        flush = 1'b0;
        setOk(1'b0, 1'b1, 32'hDEADBEEF);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        check("fl_rdata_kept", inst_rdata, 32'h33334444);
        check("fl_bus_req", {31'b0, bus_req}, 32'd0);
        inst_req = 1'b1; inst_addr = 32'h00400200;
        #1 check("fl_valid_clear", {31'b0, inst_stall}, 32'd1);
        cyc();
        check("fl_idle_regrant", {31'b0, bus_req}, 32'd1);
        setOk(1'b1, 1'b1, 32'h55556666);
        cyc();
        setOk(1'b0, 1'b0, 32'h0);
        check("fl_new_rdata", inst_rdata, 32'h55556666);

        // ---------------- async reset in ADDR ----------------
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000020;
        cyc();
        check("ar_in_addr", {31'b0, bus_req}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("ar_bus_req", {31'b0, bus_req}, 32'd0);
        check("ar_bus_addr", bus_addr, 32'd0);
        check("ar_stalls", {30'b0, inst_stall, data_stall}, 32'd3);
        check("ar_rdata", inst_rdata, 32'd0);
        inst_req = 1'b0; data_req = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 3000; n++) begin
            bus_addr_ok = (mPending && !mAddrDone) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_data_ok = (mPending && (mAddrDone || bus_addr_ok)) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_rdata   = $urandom;
            inst_req     = ($urandom_range(0, 3) != 0);
            inst_addr    = {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, 255)) << 2);
            inst_release = 1'($urandom_range(0, 1));
            data_req     = ($urandom_range(0, 2) == 0);
            data_wr      = 1'($urandom_range(0, 1));
            data_size    = 2'($urandom_range(0, 2));
            data_addr    = $urandom;
            data_wdata   = $urandom;
            data_release = 1'($urandom_range(0, 1));
            flush        = ($urandom_range(0, 15) == 0);
            cyc();
        end
        flush = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage MIPS pipeline.
- Serialises the two requesters with data-over-instruction priority, keeping one bus transaction outstanding at a time.
- Holds each completed result until the owning pipeline stage advances.
- Produces the IF and MEM stall requests consumed by the hazard unit.

Parameters:
- ADDR_W, 32, bus/request address width
- DATA_W, 32, bus/request data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- inst_req  in  1  IF wants an instruction word
- inst_addr  in  ADDR_W  fetch address (PC)
- inst_release  in  1  IF stage advances this cycle (~StallF); consumes buffered result
- inst_rdata  out  DATA_W  buffered instruction
- inst_stall  out  1  inst_req & ~inst_valid
- data_req  in  1  MEM stage load/store
- data_wr  in  1  1 = store
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_release  in  1  MEM stage advances this cycle (~StallM)
- data_rdata  out  DATA_W  buffered load data
- data_stall  out  1  data_req & ~data_valid
- flush  in  1  exception/eret flush; discard all results
- bus_req, bus_wr, bus_size[1:0], bus_addr, bus_wdata  out  bus request (all registered)
- bus_addr_ok  in  1  slave accepted address
- bus_data_ok  in  1  slave returned data / write done
- bus_rdata  in  DATA_W  read data

Behaviour:
- FSM states are IDLE, ADDR and DATA.
- Registers: owner (0 = inst, 1 = data), inst_valid, data_valid, discard, and the latched request fields.
- Reset (rst = 0, async) values:
  - state = IDLE; bus_req = 0.
  - All bus_* outputs are 0.
  - inst_valid = data_valid = discard = 0.
  - inst_rdata = data_rdata = 0.
  - An in-flight transaction is abandoned; the slave is reset by the same rst.
- IDLE:
  - If data_req & ~data_valid & ~flush: owner = 1, latch data fields, go to ADDR.
  - Else if inst_req & ~inst_valid & ~flush: owner = 0, latch {inst_addr, wr = 0, size = 2}, go to ADDR.
  - When both request in the same cycle, data wins.
- ADDR:
  - bus_req = 1, and the fields stay stable until bus_addr_ok.
  - On bus_addr_ok & ~bus_data_ok: go to DATA and drop bus_req.
  - On bus_addr_ok & bus_data_ok: complete in this cycle and go to IDLE.
- DATA: on bus_data_ok, complete and go to IDLE.
- Completion:
  - If ~discard & ~flush: set owner's valid; capture bus_rdata into the owner's rdata (stores capture too; the value is don't-care).
  - In all cases discard is cleared.
- Minimum latency with a zero-wait slave (addr_ok in cycle 1, data_ok in cycle 2):
  - Request seen in cycle 0, bus_req high in cycle 1.
  - valid is set at the end of cycle 2; stall is low from cycle 3.
- Release:
  - X_release clears X_valid on the next edge.
  - A new request then re-arbitrates, giving one idle cycle between back-to-back transactions of the same requester.
- Flush:
  - Clears inst_valid and data_valid.
  - If state is not IDLE, discard is set: the in-flight transaction still completes on the bus, but its result is dropped.
  - No new grant is made in the flush cycle.
- Valid-hold: while X_valid = 1 and no release, a held X_req does not re-issue on the bus.
- A requester dropping its req mid-transaction does not abort it; the result is buffered and valid stays set until release or flush.
- Stall outputs are combinational from req and the valid registers.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2);
  - size codes (SIZE_B/H/W);
  - OWNER_INST/OWNER_DATA.
- One natural sub-module, arb_result_buf: a per-requester valid + rdata holding register with set/release/flush. It is instantiated twice.

Test Plan:
- Single fetch:
  - Stimulus: inst_req = 1, addr 0xBFC00000, addr_ok in cycle 1, data_ok in cycle 2 with rdata 0x24080001.
  - Response: bus_req high only in cycle 1; inst_stall high in cycles 0-2 and low in cycle 3; inst_rdata = 0x24080001.
- Simultaneous requests:
  - Stimulus: inst_req and a data load to 0x80000010 in the same cycle.
  - Response: the first bus_addr is 0x80000010 (data first); the fetch issues only after data completes; data_stall falls before inst_stall.
- Store:
  - Stimulus: data_wr = 1, size = 0, addr 0x80000003, wdata 0x000000AB, slave returns addr_ok and data_ok in the same cycle.
  - Response: bus_wr = 1, bus_size = 0, one-cycle bus_req; data_valid is set the next edge.
- Hold without re-issue:
  - Stimulus: after the fetch completes, inst_req stays high with inst_release = 0 for 5 cycles.
  - Response: no new bus_req, inst_stall = 0 throughout; after inst_release, bus_req reappears 2 cycles later.
- Flush mid-transaction:
  - Stimulus: flush pulses while in DATA with owner = inst, then data_ok arrives with 0xDEADBEEF.
  - Response: inst_valid stays 0, inst_rdata is unchanged, and the FSM returns to IDLE.
- Async reset in ADDR:
  - Stimulus: assert rst = 0 between clock edges while bus_req = 1.
  - Response: bus_req = 0, both stalls reflect valid = 0, and the FSM is in IDLE immediately, without waiting for a clock edge.
